// File: rtl/quant_sched.sv
// quant_sched: schedules the shared quantizer between the forward-quant (FQ)
// and inverse-quant (IQ) requesters. It grants jobs round-robin and splits the
// clamped qp into per = qp/6 and rem = qp%6 by repeated subtraction. It then
// publishes the quantizer configuration and offers one coefficient row per
// accepted cycle.
module quant_sched #(
    parameter int unsigned QP_MAX = 51
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fq_req,
    input  logic [5:0] fq_qp,
    input  logic [1:0] fq_size,
    input  logic       fq_type,
    output logic       fq_gnt,
    output logic       fq_done,
    input  logic       iq_req,
    input  logic [5:0] iq_qp,
    input  logic [1:0] iq_size,
    input  logic       iq_type,
    output logic       iq_gnt,
    output logic       iq_done,
    output logic       q_start,
    output logic       q_inverse,
    output logic [1:0] q_transize,
    output logic       q_type,
    output logic [3:0] q_per,
    output logic [2:0] q_rem,
    output logic       q_row_valid,
    output logic [4:0] q_row_idx,
    input  logic       q_row_ready,
    output logic       busy
);

    localparam logic [5:0] QP_MAX_C = 6'(QP_MAX);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_CFG  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Clamp an incoming qp to the largest legal value.
    function automatic logic [5:0] clamp_qp(input logic [5:0] qp);
        if (qp > QP_MAX_C) begin
            return QP_MAX_C;
        end else begin
            return qp;
        end
    endfunction

    // Index of the final row of a block: (4 << size) - 1.
    function automatic logic [4:0] last_row(input logic [1:0] size);
        case (size)
            2'b00:   return 5'd3;
            2'b01:   return 5'd7;
            2'b10:   return 5'd15;
            2'b11:   return 5'd31;
            default: return 5'd3;
        endcase
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;

    logic       rr_ptr_r;      // 1: IQ wins the next tie (FQ was granted last)
    logic       owner_r;       // 1: current job belongs to IQ
    logic [5:0] opi_r;         // division remainder being reduced
    logic [3:0] per_r;         // quotient accumulated so far
    logic [1:0] size_r;
    logic       type_r;
    logic [4:0] row_r;

    logic       fq_gnt_r, iq_gnt_r, fq_done_r, iq_done_r;
    logic       q_start_r, q_inverse_r, q_type_r, q_row_valid_r, busy_r;
    logic [1:0] q_transize_r;
    logic [3:0] q_per_r;
    logic [2:0] q_rem_r;

    logic       grant_s;
    logic       pick_iq_s;
    logic [5:0] job_qp_s;
    logic [1:0] job_size_s;
    logic       job_type_s;
    logic       div_step_s;
    logic       div_end_s;
    logic       row_fire_s;
    logic       row_last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_end_s) begin
                    state_nxt_s = ST_CFG;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_CFG: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (row_fire_s && row_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state decode: arbitration winner, division progress, row handshake.
    always_comb begin
        grant_s    = 1'b0;
        pick_iq_s  = iq_req & (~fq_req | rr_ptr_r);
        job_qp_s   = fq_qp;
        job_size_s = fq_size;
        job_type_s = fq_type;
        div_step_s = 1'b0;
        div_end_s  = 1'b0;
        row_fire_s = 1'b0;
        row_last_s = (row_r == last_row(size_r));
        if (state_r == ST_IDLE) begin
            grant_s = fq_req | iq_req;
        end else begin
            grant_s = 1'b0;
        end
        if (pick_iq_s) begin
            job_qp_s   = iq_qp;
            job_size_s = iq_size;
            job_type_s = iq_type;
        end else begin
            job_qp_s   = fq_qp;
            job_size_s = fq_size;
            job_type_s = fq_type;
        end
        if (state_r == ST_DIV) begin
            div_step_s = (opi_r >= 6'd6);
            div_end_s  = (opi_r <  6'd6);
        end else begin
            div_step_s = 1'b0;
            div_end_s  = 1'b0;
        end
        if (state_r == ST_RUN) begin
            row_fire_s = q_row_ready;
        end else begin
            row_fire_s = 1'b0;
        end
    end

    // Job datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r      <= 1'b0;
            owner_r       <= 1'b0;
            opi_r         <= 6'd0;
            per_r         <= 4'd0;
            size_r        <= 2'd0;
            type_r        <= 1'b0;
            row_r         <= 5'd0;
            fq_gnt_r      <= 1'b0;
            iq_gnt_r      <= 1'b0;
            fq_done_r     <= 1'b0;
            iq_done_r     <= 1'b0;
            q_start_r     <= 1'b0;
            q_inverse_r   <= 1'b0;
            q_transize_r  <= 2'd0;
            q_type_r      <= 1'b0;
            q_per_r       <= 4'd0;
            q_rem_r       <= 3'd0;
            q_row_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            fq_gnt_r <= grant_s & ~pick_iq_s;
            iq_gnt_r <= grant_s &  pick_iq_s;

            if (grant_s) begin
                owner_r  <= pick_iq_s;
                rr_ptr_r <= ~pick_iq_s;
                opi_r    <= clamp_qp(job_qp_s);
                per_r    <= 4'd0;
                size_r   <= job_size_s;
                type_r   <= job_type_s;
            end else if (div_step_s) begin
                opi_r <= opi_r - 6'd6;
                per_r <= per_r + 4'd1;
            end

            // Configuration is published once and then held until the next job.
            q_start_r <= div_end_s;
            if (div_end_s) begin
                q_inverse_r  <= owner_r;
                q_transize_r <= size_r;
                q_type_r     <= type_r;
                q_per_r      <= per_r;
                q_rem_r      <= opi_r[2:0];
            end

            // Row index restarts per job and stops at the last row (no wrap).
            if (state_r == ST_CFG) begin
                row_r <= 5'd0;
            end else if (row_fire_s && !row_last_s) begin
                row_r <= row_r + 5'd1;
            end

            q_row_valid_r <= (state_nxt_s == ST_RUN);
            fq_done_r     <= (state_nxt_s == ST_DONE) & (state_r == ST_RUN) & ~owner_r;
            iq_done_r     <= (state_nxt_s == ST_DONE) & (state_r == ST_RUN) &  owner_r;
            busy_r        <= (state_nxt_s != ST_IDLE);
        end
    end

    assign fq_gnt      = fq_gnt_r;
    assign iq_gnt      = iq_gnt_r;
    assign fq_done     = fq_done_r;
    assign iq_done     = iq_done_r;
    assign q_start     = q_start_r;
    assign q_inverse   = q_inverse_r;
    assign q_transize  = q_transize_r;
    assign q_type      = q_type_r;
    assign q_per       = q_per_r;
    assign q_rem       = q_rem_r;
    assign q_row_valid = q_row_valid_r;
    assign q_row_idx   = row_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_quant_sched.sv
// Directed bench for quant_sched: single jobs on each requester, qp clamping
// and the qp=0 corner, row back-pressure, reset during a job and round-robin
// alternation under continuous contention.
module tb_quant_sched;

    logic       clk;
    logic       rst;
    logic       fq_req, iq_req;
    logic [5:0] fq_qp, iq_qp;
    logic [1:0] fq_size, iq_size;
    logic       fq_type, iq_type;
    logic       fq_gnt, fq_done, iq_gnt, iq_done;
    logic       q_start, q_inverse, q_type, q_row_valid, q_row_ready, busy;
    logic [1:0] q_transize;
    logic [3:0] q_per;
    logic [2:0] q_rem;
    logic [4:0] q_row_idx;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    quant_sched #(.QP_MAX(51)) dut (
        .clk(clk), .rst(rst),
        .fq_req(fq_req), .fq_qp(fq_qp), .fq_size(fq_size), .fq_type(fq_type),
        .fq_gnt(fq_gnt), .fq_done(fq_done),
        .iq_req(iq_req), .iq_qp(iq_qp), .iq_size(iq_size), .iq_type(iq_type),
        .iq_gnt(iq_gnt), .iq_done(iq_done),
        .q_start(q_start), .q_inverse(q_inverse), .q_transize(q_transize),
        .q_type(q_type), .q_per(q_per), .q_rem(q_rem),
        .q_row_valid(q_row_valid), .q_row_idx(q_row_idx),
        .q_row_ready(q_row_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({fq_gnt, fq_done, iq_gnt, iq_done, q_start, q_inverse, q_transize,
                    q_type, q_per, q_rem, q_row_valid, q_row_idx, busy});
    endfunction

    // Called in the grant cycle; returns in the IDLE cycle after DONE.
    // steps = cycles from the grant cycle to the DONE cycle.
    task automatic run_job(input bit is_iq, input logic [1:0] size, input bit typ,
                           input int per, input int rem, input int div_len,
                           input int nrows, input bit toggle, output int steps);
        int n, e, g, idx_bad;
        bit rdy;
        logic [3:0] pat;
        pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)
        n = 0;
        while (q_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("div_len", 32'(n), 32'(div_len));
        chk("q_inverse", 32'(q_inverse), 32'(is_iq));
        chk("q_transize", 32'(q_transize), 32'(size));
        chk("q_type", 32'(q_type), 32'(typ));
        chk("q_per", 32'(q_per), 32'(per));
        chk("q_rem", 32'(q_rem), 32'(rem));
        chk("cfg_no_valid_no_gnt", 32'({q_row_valid, fq_gnt, iq_gnt}), 32'd0);
        step();
        e = 0;
        g = 0;
        idx_bad = 0;
        while (q_row_valid === 1'b1 && g < 200) begin
            if (q_row_idx !== 5'(e)) idx_bad++;
            rdy = toggle ? pat[g % 4] : 1'b1;
            q_row_ready = rdy;
            step();
            g++;
            if (rdy) e++;
        end
        q_row_ready = 1'b1;
        chk("rows", 32'(e), 32'(nrows));
        chk("row_idx_seq_errs", 32'(idx_bad), 32'd0);
        chk("done_owner", 32'(is_iq ? iq_done : fq_done), 32'd1);
        chk("done_other", 32'(is_iq ? fq_done : iq_done), 32'd0);
        chk("gnt_in_done", 32'({fq_gnt, iq_gnt}), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        steps = n + 1 + g;
        step();
        chk("done_one_cycle", 32'({fq_done, iq_done}), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int st;
        int dcount;
        rst = 1'b0;
        fq_req = 1'b0; iq_req = 1'b0;
        fq_qp = 6'd0; iq_qp = 6'd0;
        fq_size = 2'd0; iq_size = 2'd0;
        fq_type = 1'b0; iq_type = 1'b0;
        q_row_ready = 1'b1;
        step();
        step();
        chk("reset_outputs", all_outs(), 32'd0);
        rst = 1'b1;

        // FQ qp=27 4x4: per 4, rem 3, 5-cycle DIV; done 11 cycles after the
        // request cycle (12 cycles counting both).
        fq_req = 1'b1; fq_qp = 6'd27; fq_size = 2'b00; fq_type = 1'b1;
        step();
        chk("fq_gnt", 32'({fq_gnt, iq_gnt}), 32'b10);
        chk("busy_after_gnt", 32'(busy), 32'd1);
        fq_req = 1'b0;
        run_job(1'b0, 2'b00, 1'b1, 4, 3, 5, 4, 1'b0, st);
        chk("req_to_done", 32'(st + 1), 32'd11);

        // IQ qp=51 32x32.
        iq_req = 1'b1; iq_qp = 6'd51; iq_size = 2'b11; iq_type = 1'b0;
        step();
        chk("iq_gnt", 32'({fq_gnt, iq_gnt}), 32'b01);
        iq_req = 1'b0;
        run_job(1'b1, 2'b11, 1'b0, 8, 3, 9, 32, 1'b0, st);

        // qp=63 clamps to 51.
        fq_req = 1'b1; fq_qp = 6'd63; fq_size = 2'b10; fq_type = 1'b0;
        step();
        chk("fq_gnt_clamp", 32'({fq_gnt, iq_gnt}), 32'b10);
        fq_req = 1'b0;
        run_job(1'b0, 2'b10, 1'b0, 8, 3, 9, 16, 1'b0, st);

        // qp=0: single DIV cycle.
        fq_req = 1'b1; fq_qp = 6'd0; fq_size = 2'b00; fq_type = 1'b1;
        step();
        fq_req = 1'b0;
        run_job(1'b0, 2'b00, 1'b1, 0, 0, 1, 4, 1'b0, st);

        // Back-pressure on an 8x8 job, qp=20: per 3, rem 2.
        fq_req = 1'b1; fq_qp = 6'd20; fq_size = 2'b01; fq_type = 1'b0;
        step();
        fq_req = 1'b0;
        run_job(1'b0, 2'b01, 1'b0, 3, 2, 4, 8, 1'b1, st);

        // Reset while row 5 of an 8x8 job is on offer.
        fq_req = 1'b1; fq_qp = 6'd0; fq_size = 2'b01; fq_type = 1'b1;
        step();
        fq_req = 1'b0;
        step();
        chk("q_start_qp0", 32'(q_start), 32'd1);
        step();
        repeat (5) step();
        chk("row5_idx", 32'({q_row_valid, q_row_idx}), 32'({1'b1, 5'd5}));
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_run_reset_outputs", all_outs(), 32'd0);
        dcount = 0;
        repeat (3) begin
            step();
            dcount = dcount + int'(fq_done) + int'(iq_done) + int'(busy);
        end
        chk("no_done_after_reset", 32'(dcount), 32'd0);
        fq_req = 1'b1; fq_qp = 6'd13; fq_size = 2'b00; fq_type = 1'b0;
        step();
        chk("fresh_gnt", 32'({fq_gnt, iq_gnt}), 32'b10);
        fq_req = 1'b0;
        run_job(1'b0, 2'b00, 1'b0, 2, 1, 3, 4, 1'b0, st);

        // Contention right after reset: FQ, IQ, FQ, IQ.
        rst = 1'b0;
        step();
        rst = 1'b1;
        fq_req = 1'b1; fq_qp = 6'd6;  fq_size = 2'b00; fq_type = 1'b0;
        iq_req = 1'b1; iq_qp = 6'd35; iq_size = 2'b01; iq_type = 1'b1;
        step();
        chk("tie1_fq", 32'({fq_gnt, iq_gnt}), 32'b10);
        fq_req = 1'b0;
        run_job(1'b0, 2'b00, 1'b0, 1, 0, 2, 4, 1'b0, st);
        fq_req = 1'b1; fq_qp = 6'd12;
        step();
        chk("tie2_iq", 32'({fq_gnt, iq_gnt}), 32'b01);
        iq_req = 1'b0;
        run_job(1'b1, 2'b01, 1'b1, 5, 5, 6, 8, 1'b0, st);
        iq_req = 1'b1; iq_qp = 6'd5; iq_size = 2'b00; iq_type = 1'b0;
        step();
        chk("tie3_fq", 32'({fq_gnt, iq_gnt}), 32'b10);
        fq_req = 1'b0;
        run_job(1'b0, 2'b00, 1'b0, 2, 0, 3, 4, 1'b0, st);
        step();
        chk("job4_iq", 32'({fq_gnt, iq_gnt}), 32'b01);
        iq_req = 1'b0;
        run_job(1'b1, 2'b00, 1'b0, 0, 5, 1, 4, 1'b0, st);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
